// File: rtl/rr_lock_arbiter_pkg.sv
// Shared arbitration types: FSM state encoding used by the lock arbiter.
package rr_lock_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream sink.
interface rr_lock_arbiter_if #(
  parameter int NUM_REQUESTERS = 4
);
  logic [NUM_REQUESTERS-1:0] request;
  logic [NUM_REQUESTERS-1:0] request_last;
  logic                      grant_ready;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic                      grant_valid;

  modport master (
    input  request, request_last, grant_ready,
    output grant_oh, grant_valid
  );

  modport slave (
    output request, request_last, grant_ready,
    input  grant_oh, grant_valid
  );
endinterface

// File: rtl/rr_lock_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping, as one-hot.
module rr_pick #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic [NUM_REQUESTERS-1:0]         request_i,
  input  logic [$clog2(NUM_REQUESTERS)-1:0] ptr_i,
  output logic [NUM_REQUESTERS-1:0]         pick_oh_o
);
  localparam int PTR_W = $clog2(NUM_REQUESTERS);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pick_oh_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQUESTERS;
      if (!found && request_i[PTR_W'(idx)]) begin
        pick_oh_o[PTR_W'(idx)] = 1'b1;
        found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with packet locking, beat-limited hold and same-cycle re-arbitration.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int LOCKING        = 1,
  parameter int MAX_LOCK_BEATS = 16
) (
  input  logic                clk,
  input  logic                reset,
  rr_lock_arbiter_if.master   bus
);
  localparam int PTR_W  = $clog2(NUM_REQUESTERS);
  localparam int BEAT_W = $clog2(MAX_LOCK_BEATS + 1);

  arb_state_e                state_q;
  logic [NUM_REQUESTERS-1:0] grant_oh_q;
  logic                      grant_valid_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [PTR_W-1:0]          ptr_q;

  logic [PTR_W-1:0]          gidx;
  logic [PTR_W-1:0]          arb_ptr;
  logic [NUM_REQUESTERS-1:0] pick_oh;
  logic                      transfer;
  logic                      last_beat;
  logic                      release_grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_oh_q[i]) gidx = PTR_W'(i);
    end
  end

  assign transfer      = grant_valid_q & bus.grant_ready;
  assign last_beat     = (beat_q == BEAT_W'(MAX_LOCK_BEATS - 1));
  assign release_grant = transfer && ((LOCKING == 0) || bus.request_last[gidx] || last_beat);
  // Re-arbitrate from the releasing index so the releaser drops to lowest priority this cycle.
  assign arb_ptr       = release_grant ? gidx : ptr_q;

  rr_pick #(
    .NUM_REQUESTERS (NUM_REQUESTERS)
  ) u_pick (
    .request_i (bus.request),
    .ptr_i     (arb_ptr),
    .pick_oh_o (pick_oh)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_oh_q    <= '0;
      grant_valid_q <= 1'b0;
      beat_q        <= '0;
      ptr_q         <= PTR_W'(NUM_REQUESTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.request) begin
            grant_oh_q    <= pick_oh;
            grant_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (release_grant) begin
            ptr_q         <= gidx;
            beat_q        <= '0;
            grant_oh_q    <= pick_oh;
            grant_valid_q <= |bus.request;
            state_q       <= (|bus.request) ? HOLD : IDLE;
          end else if (transfer) begin
            beat_q <= beat_q + 1'b1;
          end else if (!bus.request[gidx]) begin
            // Requester abandoned its grant without finishing: recover, pointer untouched.
            grant_oh_q    <= '0;
            grant_valid_q <= 1'b0;
            beat_q        <= '0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_oh    = grant_oh_q;
  assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench: directed vector tables, hand sequences and a randomized reference-model run.
module tb_rr_lock_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic clk;
  logic reset;

  rr_lock_arbiter_if #(.NUM_REQUESTERS(N)) a_if ();
  rr_lock_arbiter_if #(.NUM_REQUESTERS(N)) b_if ();

  rr_lock_arbiter #(.NUM_REQUESTERS(N), .LOCKING(1), .MAX_LOCK_BEATS(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.master)
  );

  rr_lock_arbiter #(.NUM_REQUESTERS(N), .LOCKING(0), .MAX_LOCK_BEATS(MAXB)) dut_nl (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] last;
    bit         ready;
    logic [3:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    int owner;
    int ptr;
    int beats;
  } mstate_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic [3:0] req, input logic [3:0] last, input bit ready);
    a_if.request      = req;
    a_if.request_last = last;
    a_if.grant_ready  = ready;
  endtask

  task automatic drive_b(input logic [3:0] req, input logic [3:0] last, input bit ready);
    b_if.request      = req;
    b_if.request_last = last;
    b_if.grant_ready  = ready;
  endtask

  // Called at a falling edge; leaves reset deasserted at a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    drive_a('0, '0, 1'b0);
    drive_b('0, '0, 1'b0);
    @(negedge clk);
    check("reset_grant_a", a_if.grant_oh, 0);
    check("reset_valid_a", a_if.grant_valid, 0);
    check("reset_grant_b", b_if.grant_oh, 0);
    reset = 1'b1;
  endtask

  task automatic cycle_a(input logic [3:0] req, input logic [3:0] last, input bit ready,
                         input logic [3:0] exp, input string name);
    drive_a(req, last, ready);
    @(negedge clk);
    check({name, "_grant"}, a_if.grant_oh, exp);
    check({name, "_valid"}, a_if.grant_valid, (exp != 0));
  endtask

  function automatic int pick_ref(input int ptr, input logic [3:0] req);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input bit lock, input logic [3:0] req,
                                         input logic [3:0] last, input bit ready);
    mstate_t n;
    n = s;
    if (s.owner < 0) begin
      n.owner = pick_ref(s.ptr, req);
    end else if (ready) begin
      if (!lock || last[s.owner] || s.beats == MAXB - 1) begin
        n.ptr   = s.owner;
        n.beats = 0;
        n.owner = pick_ref(n.ptr, req);
      end else begin
        n.beats = s.beats + 1;
      end
    end else if (!req[s.owner]) begin
      n.owner = -1;
      n.beats = 0;
    end
    return n;
  endfunction

  function automatic logic [3:0] model_oh(input mstate_t s);
    logic [3:0] oh;
    oh = '0;
    if (s.owner >= 0) oh[s.owner] = 1'b1;
    return oh;
  endfunction

  function automatic logic [3:0] sticky_req(input logic [3:0] prev);
    logic [3:0] r;
    for (int i = 0; i < N; i++)
      r[i] = prev[i] ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
    return r;
  endfunction

  initial begin
    mstate_t    sa, sb, na, nb;
    logic [3:0] ra, rb, la, lb;
    bit         ya, yb;

    reset = 1'b0;
    drive_a('0, '0, 1'b0);
    drive_b('0, '0, 1'b0);
    @(negedge clk);

    // Alternation with last every beat, no bubbles.
    vecs.push_back('{1'b1, 4'b0101, 4'b1111, 1'b1, 4'b0001, "alt0"});
    vecs.push_back('{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0100, "alt1"});
    vecs.push_back('{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0001, "alt2"});
    vecs.push_back('{1'b0, 4'b0101, 4'b1111, 1'b1, 4'b0100, "alt3"});
    // Three-beat packet with a stalled beat; request drops on the final beat.
    vecs.push_back('{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, "pkt0"});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, "pkt1"});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, "pkt2"});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, "pkt3"});
    vecs.push_back('{1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, "pkt4"});
    // Forced release after MAX_LOCK_BEATS transfers.
    vecs.push_back('{1'b1, 4'b0011, 4'b0000, 1'b1, 4'b0001, "max0"});
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, "max1"});
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, "max2"});
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, "max3"});
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, "max4"});
    vecs.push_back('{1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, "max5"});
    // Grant stable in HOLD while other requests change, then release to next in order.
    vecs.push_back('{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, "hold0"});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, "hold1"});
    vecs.push_back('{1'b0, 4'b1011, 4'b0000, 1'b0, 4'b0001, "hold2"});
    vecs.push_back('{1'b0, 4'b1011, 4'b0001, 1'b1, 4'b0010, "hold3"});
    // Granted requester drops without a transfer: drop grant, pointer unchanged.
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, "drop0"});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "drop1"});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "drop2"});
    vecs.push_back('{1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, "drop3"});
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, "dptr0"});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, "dptr1"});
    vecs.push_back('{1'b0, 4'b1100, 4'b0000, 1'b0, 4'b0100, "dptr2"});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cycle_a(vecs[i].req, vecs[i].last, vecs[i].ready, vecs[i].exp, vecs[i].name);
    end

    // Non-locking instance: every transfer releases, full rotation.
    do_reset();
    drive_b(4'b1111, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_b;
      exp_b = '0;
      exp_b[i % N] = 1'b1;
      @(negedge clk);
      check($sformatf("nolock%0d_grant", i), b_if.grant_oh, exp_b);
      check($sformatf("nolock%0d_valid", i), b_if.grant_valid, 1);
    end

    // Reset mid-packet clears asynchronously; requester 0 wins first afterwards.
    do_reset();
    cycle_a(4'b0010, 4'b0000, 1'b0, 4'b0010, "arst0");
    cycle_a(4'b0010, 4'b0000, 1'b1, 4'b0010, "arst1");
    #2;
    reset = 1'b0;
    drive_a(4'b0011, 4'b0000, 1'b1);
    #1;
    check("arst_async_grant", a_if.grant_oh, 0);
    check("arst_async_valid", a_if.grant_valid, 0);
    @(negedge clk);
    check("arst_held_grant", a_if.grant_oh, 0);
    reset = 1'b1;
    #1;
    check("arst_no_early_grant", a_if.grant_oh, 0);
    @(negedge clk);
    check("arst_first_grant", a_if.grant_oh, 4'b0001);
    check("arst_first_valid", a_if.grant_valid, 1);

    // Randomized run of both instances against the reference model.
    do_reset();
    sa = '{-1, N - 1, 0};
    sb = '{-1, N - 1, 0};
    ra = '0;
    rb = '0;
    for (int c = 0; c < 1500; c++) begin
      ra = sticky_req(ra);
      rb = sticky_req(rb);
      la = 4'($urandom_range(15)) & 4'($urandom_range(15));
      lb = 4'($urandom_range(15));
      ya = ($urandom_range(3) != 0);
      yb = ($urandom_range(3) != 0);
      na = model_next(sa, 1'b1, ra, la, ya);
      nb = model_next(sb, 1'b0, rb, lb, yb);
      drive_a(ra, la, ya);
      drive_b(rb, lb, yb);
      @(negedge clk);
      sa = na;
      sb = nb;
      check("rand_a_grant", a_if.grant_oh, model_oh(sa));
      check("rand_a_valid", a_if.grant_valid, (sa.owner >= 0));
      check("rand_a_onehot", ($countones(a_if.grant_oh) <= 1), 1);
      check("rand_b_grant", b_if.grant_oh, model_oh(sb));
      check("rand_b_valid", b_if.grant_valid, (sb.owner >= 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4: number of requesters; legal values are 2 or more.
REQ-002 Parameter LOCKING, default 1: when 1, a grant holds until a transfer with request_last; when 0, every transfer releases the grant.
REQ-003 Parameter MAX_LOCK_BEATS, default 16: maximum number of transfers in one grant before a forced release; legal values are 1 or more.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 request  input  NUM_REQUESTERS  per-requester request; a requester SHALL hold its bit high until its grant releases.
REQ-007 request_last  input  NUM_REQUESTERS  per-requester end-of-packet flag; sampled only for the granted requester on a transfer.
REQ-008 grant_ready  input  1  downstream can accept this cycle.
REQ-009 grant_oh  output  NUM_REQUESTERS  registered grant; one-hot or zero; LSB is requester 0; feeds the downstream one-hot-to-index converter.
REQ-010 grant_valid  output  1  registered; high exactly when grant_oh is non-zero.

Function
REQ-011 A transfer SHALL occur in any cycle where grant_valid and grant_ready are both high.
REQ-012 The FSM SHALL have two states: IDLE (no grant) and HOLD (grant registered).
REQ-013 Round-robin pick rule: scan requesters starting at index (pointer+1) mod NUM_REQUESTERS and select the first with request high.
REQ-014 IDLE with any request bit high at edge t: grant_oh SHALL be the round-robin pick and grant_valid SHALL be 1 from t+1, and the FSM enters HOLD; this is 1-cycle latency.
REQ-015 IDLE with no request: outputs SHALL stay zero and the FSM stays in IDLE.
REQ-016 HOLD without a transfer: grant_oh SHALL stay stable, even if other requests change.
REQ-017 A release SHALL occur on a transfer when any of these holds: LOCKING=0, request_last of the granted requester is 1, or the beat counter equals MAX_LOCK_BEATS-1.
REQ-018 A transfer without a release SHALL increment the beat counter and keep the grant.
REQ-019 On release, the pointer SHALL take the granted index and the beat counter SHALL clear.
REQ-020 On release, arbitration SHALL re-run in the same cycle using the updated pointer, with no bubble:
- if any request is high, the new grant is valid at the next edge and the FSM stays in HOLD;
- otherwise the FSM goes to IDLE.
REQ-021 The releasing requester SHALL be eligible again, but at the lowest priority.
REQ-022 In HOLD, if the granted requester's request bit is low and no transfer occurs, the arbiter SHALL drop the grant at the next edge and go to IDLE. The pointer SHALL be unchanged and the beat counter cleared; this is a protocol-violation recovery.
REQ-023 The beat counter SHALL be $clog2(MAX_LOCK_BEATS+1) bits wide and SHALL never exceed MAX_LOCK_BEATS-1.
REQ-024 grant_oh SHALL never have more than one bit set, in any cycle.
REQ-025 The pointer SHALL wrap from NUM_REQUESTERS-1 to 0.

Reset
REQ-026 While reset is low, the arbiter SHALL clear asynchronously: grant_oh=0, grant_valid=0, FSM=IDLE, beat counter=0, pointer=NUM_REQUESTERS-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-HOLD SHALL abort the grant immediately, with no completion of the transfer.
REQ-028 The first grant SHALL be no earlier than the first rising edge after reset deasserts.

Structure
REQ-029 The FSM state enum typedef (IDLE, HOLD) SHALL live in the shared arbitration package.
REQ-030 The round-robin pick SHALL be one combinational sub-module, rr_pick. It takes request and pointer and outputs a one-hot pick; rotate-mask-priority is the permitted implementation.
REQ-031 The outputs SHALL be driven directly from flops, with no combinational path from grant_ready to grant_oh.

Verification (NUM_REQUESTERS=4, LOCKING=1, MAX_LOCK_BEATS=4 unless noted)
REQ-032 Reset release, then request=0101 held with grant_ready=1 and last=1 every beat -> grant_oh sequence 0001, 0100, 0001, 0100 on consecutive cycles with no bubbles.
REQ-033 request=0010 with a 3-beat packet (last on beat 3), grant_ready toggled 1,0,1,1 -> grant_oh=0010 held for 4 cycles, then 0000 the cycle after the third transfer.
REQ-034 request=0011 with last never asserted and grant_ready=1 -> requester 0 gets exactly 4 transfers (forced release), then grant_oh=0010 on the next cycle.
REQ-035 LOCKING=0, request=1111, grant_ready=1 -> grant_oh cycles 0001, 0010, 0100, 1000, 0001.
REQ-036 Granted requester 2 drops request with grant_ready=0 -> grant_oh=0000 next cycle, the FSM is in IDLE, and the pointer is unchanged (the next pick from request=0101 is 0001 if the pointer is 3).
REQ-037 reset asserted mid-packet -> grant_oh=0 and grant_valid=0 with no clock edge, and after deassertion requester 0 wins first.
